// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path:
// FSM states, opcode constants, instruction classes and datapath mux selects.
package multicycle_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEMACC, WB, TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I_ALU  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  typedef enum logic [3:0] {
    CLS_R, CLS_I_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
  } class_e;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_BUS     = 2'd2;

  function automatic class_e decodeClass(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return CLS_R;
      OP_I_ALU:  return CLS_I_ALU;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      OP_LUI:    return CLS_LUI;
      OP_AUIPC:  return CLS_AUIPC;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags the cycle in which the
// stall budget is used up; MEM_TIMEOUT of 0 disables the check.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req,
  input  logic ready,
  input  logic clr,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] count_q, count_d;
  logic          waiting;

  assign waiting = req && !ready;
  // The current stalled cycle is the last one allowed, so a ready in it still wins.
  assign expired = (MEM_TIMEOUT != 0) && waiting && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr || !waiting) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back,
// raises a sticky trap on illegal opcodes or bus timeouts and counts retirements.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             ir_write_o,
  output logic             iord_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             reg_write_o,
  output logic [1:0]       wb_sel_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  class_e           decodedCls;
  logic [1:0]       trapCause_q, trapCause_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             expired;
  logic             unusedFunct3;

  assign decodedCls   = decodeClass(opcode_i);
  assign unusedFunct3 = ^funct3_i[2:1];

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) uTimer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (mem_req_o),
    .ready   (mem_ready_i),
    .clr     (state_d != state_q),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    trapCause_d = trapCause_q;
    retire      = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 1'b0;
    ir_write_o  = 1'b0;
    iord_o      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    reg_write_o = 1'b0;
    wb_sel_o    = WB_ALUOUT;
    alu_src_a_o = SRCA_PC;
    alu_src_b_o = SRCB_RS2;
    alu_op_o    = ALU_ADD;
    case (state_q)
      FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end else if (expired) begin
          state_d     = TRAP;
          trapCause_d = CAUSE_BUS;
        end
      end
      DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        if (decodedCls == CLS_ILLEGAL) begin
          state_d     = TRAP;
          trapCause_d = CAUSE_ILLEGAL;
        end else begin
          class_d = decodedCls;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (class_q)
          CLS_R: begin
            alu_src_a_o = SRCA_RS1;
            alu_op_o    = ALU_FUNCT;
            state_d     = WB;
          end
          CLS_I_ALU: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALU_FUNCT;
            state_d     = WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_IMM;
            state_d     = MEMACC;
          end
          CLS_BRANCH: begin
            // funct3[0] distinguishes BNE from BEQ by inverting the zero test.
            alu_src_a_o = SRCA_RS1;
            alu_op_o    = ALU_SUB;
            pc_write_o  = zero_i ^ funct3_i[0];
            pc_src_o    = 1'b1;
            retire      = 1'b1;
            state_d     = FETCH;
          end
          CLS_JAL: begin
            pc_write_o  = 1'b1;
            pc_src_o    = 1'b1;
            reg_write_o = 1'b1;
            wb_sel_o    = WB_PC;
            retire      = 1'b1;
            state_d     = FETCH;
          end
          CLS_JALR: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_IMM;
            pc_write_o  = 1'b1;
            reg_write_o = 1'b1;
            wb_sel_o    = WB_PC;
            retire      = 1'b1;
            state_d     = FETCH;
          end
          CLS_LUI: begin
            alu_src_a_o = SRCA_ZERO;
            alu_src_b_o = SRCB_IMM;
            state_d     = WB;
          end
          CLS_AUIPC: begin
            alu_src_a_o = SRCA_OLDPC;
            alu_src_b_o = SRCB_IMM;
            state_d     = WB;
          end
          default: state_d = FETCH;
        endcase
      end
      MEMACC: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = (class_q == CLS_STORE);
        if (mem_ready_i) begin
          if (class_q == CLS_STORE) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (expired) begin
          state_d     = TRAP;
          trapCause_d = CAUSE_BUS;
        end
      end
      WB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = (class_q == CLS_LOAD) ? WB_MDR : WB_ALUOUT;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      default: ;
    endcase
    // Control lines must be quiet for the whole reset pulse, not just after it.
    if (rst_i) begin
      retire      = 1'b0;
      pc_write_o  = 1'b0;
      pc_src_o    = 1'b0;
      ir_write_o  = 1'b0;
      iord_o      = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      reg_write_o = 1'b0;
      wb_sel_o    = 2'd0;
      alu_src_a_o = 2'd0;
      alu_src_b_o = 2'd0;
      alu_op_o    = 2'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FETCH;
      class_q     <= CLS_R;
      trapCause_q <= CAUSE_NONE;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      trapCause_q <= trapCause_d;
      if (retire) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign trap_o       = (state_q == TRAP) && !rst_i;
  assign trap_cause_o = trapCause_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into the
// per-cycle control words the instruction should produce, then replayed cycle by cycle.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 4;

  typedef struct packed {
    logic       pcWrite;
    logic       pcSrc;
    logic       irWrite;
    logic       iord;
    logic       memReq;
    logic       memWe;
    logic       regWrite;
    logic [1:0] wbSel;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [1:0] aluOp;
    logic       trap;
    logic [1:0] cause;
  } ctrl_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [6:0]    opcode_i;
  logic [2:0]    funct3_i;
  logic          zero_i;
  logic          mem_ready_i;
  logic          pc_write_o, pc_src_o, ir_write_o, iord_o, mem_req_o, mem_we_o, reg_write_o;
  logic [1:0]    wb_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o;
  logic          trap_o;
  logic [1:0]    trap_cause_o;
  logic [CW-1:0] instret_o;
  ctrl_t         actWord;

  int            totalCount = 0;
  int            passCount  = 0;
  logic [CW-1:0] expInstret = '0;

  string tagQ[$];
  logic  readyQ[$];
  ctrl_t expQ[$];
  bit    retQ[$];

  logic [6:0] legalOps[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .ir_write_o   (ir_write_o),
    .iord_o       (iord_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .reg_write_o  (reg_write_o),
    .wb_sel_o     (wb_sel_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .trap_o       (trap_o),
    .trap_cause_o (trap_cause_o),
    .instret_o    (instret_o)
  );

  always #5 clk = ~clk;

  assign actWord = {pc_write_o, pc_src_o, ir_write_o, iord_o, mem_req_o, mem_we_o, reg_write_o,
                    wb_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o, trap_o, trap_cause_o};

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input string tag, input logic rdy, input ctrl_t w, input bit ret);
    tagQ.push_back(tag);
    readyQ.push_back(rdy);
    expQ.push_back(w);
    retQ.push_back(ret);
  endtask

  // Expected control words per cycle, written straight from the instruction table.
  task automatic buildInstr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                            input int fw, input int mw);
    ctrl_t w;
    bit    needWb;
    bit    isMem;
    logic  wbMdr;
    opcode_i = op;
    funct3_i = f3;
    zero_i   = z;
    for (int i = 0; i < fw; i++) begin
      w = '0; w.memReq = 1; w.srcB = 2'd1;
      push("fetchWait", 1'b0, w, 0);
    end
    w = '0; w.memReq = 1; w.srcB = 2'd1; w.irWrite = 1; w.pcWrite = 1;
    push("fetch", 1'b1, w, 0);
    w = '0; w.srcA = 2'd2; w.srcB = 2'd2;
    push("decode", 1'($urandom), w, 0);
    needWb = 0; isMem = 0; wbMdr = 0;
    w = '0;
    case (op)
      7'h33: begin w.srcA = 2'd1; w.aluOp = 2'd2; needWb = 1; end
      7'h13: begin w.srcA = 2'd1; w.srcB = 2'd2; w.aluOp = 2'd2; needWb = 1; end
      7'h03: begin w.srcA = 2'd1; w.srcB = 2'd2; isMem = 1; needWb = 1; wbMdr = 1; end
      7'h23: begin w.srcA = 2'd1; w.srcB = 2'd2; isMem = 1; end
      7'h63: begin w.srcA = 2'd1; w.aluOp = 2'd1; w.pcWrite = z ^ f3[0]; w.pcSrc = 1; end
      7'h6F: begin w.pcWrite = 1; w.pcSrc = 1; w.regWrite = 1; w.wbSel = 2'd2; end
      7'h67: begin w.srcA = 2'd1; w.srcB = 2'd2; w.pcWrite = 1; w.regWrite = 1; w.wbSel = 2'd2; end
      7'h37: begin w.srcA = 2'd3; w.srcB = 2'd2; needWb = 1; end
      7'h17: begin w.srcA = 2'd2; w.srcB = 2'd2; needWb = 1; end
      default: begin
        w.trap = 1; w.cause = 2'd1;
        for (int i = 0; i < 3; i++) push("trapIllegal", 1'($urandom), w, 0);
        return;
      end
    endcase
    push("exec", 1'($urandom), w, !(needWb || isMem));
    if (isMem) begin
      w = '0; w.memReq = 1; w.iord = 1; w.memWe = (op == 7'h23);
      for (int i = 0; i < mw; i++) push("memWait", 1'b0, w, 0);
      push("memAcc", 1'b1, w, !needWb);
    end
    if (needWb) begin
      w = '0; w.regWrite = 1; w.wbSel = wbMdr ? 2'd1 : 2'd0;
      push("wb", 1'($urandom), w, 1);
    end
  endtask

  // Entered and left at a falling edge; inputs change there and outputs are sampled 1ns later.
  task automatic applyStimulus();
    while (tagQ.size() > 0) begin
      string t;
      ctrl_t e;
      bit    r;
      t = tagQ.pop_front();
      e = expQ.pop_front();
      r = retQ.pop_front();
      mem_ready_i = readyQ.pop_front();
      #1;
      checkOutput(t, 32'(actWord), 32'(e));
      checkOutput({t, "/instret"}, 32'(instret_o), 32'(expInstret));
      if (r) expInstret = expInstret + 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    tagQ.delete(); readyQ.delete(); expQ.delete(); retQ.delete();
    rst_i = 1'b1;
    mem_ready_i = 1'($urandom);
    #1;
    checkOutput("rstOutputs", 32'(actWord), 32'd0);
    checkOutput("rstInstret", 32'(instret_o), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rstOutputsHeld", 32'(actWord), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    expInstret = '0;
  endtask

  initial begin
    rst_i = 1'b1; opcode_i = '0; funct3_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk);
    doReset();

    buildInstr(7'h33, 3'($urandom), 1'($urandom), 0, 0);
    applyStimulus();
    buildInstr(7'h03, 3'd2, 1'b0, 0, 3);
    applyStimulus();
    buildInstr(7'h63, 3'd0, 1'b1, 0, 0);
    applyStimulus();
    buildInstr(7'h63, 3'd1, 1'b1, 0, 0);
    applyStimulus();

    for (int n = 0; n < 40; n++) begin
      buildInstr(legalOps[$urandom_range(8)], 3'($urandom), 1'($urandom),
                 $urandom_range(3), $urandom_range(3));
      applyStimulus();
    end

    doReset();
    for (int n = 0; n < 16; n++) begin
      buildInstr(7'h6F, 3'($urandom), 1'($urandom), $urandom_range(2), 0);
      applyStimulus();
    end
    #1;
    checkOutput("instretWrap", 32'(instret_o), 32'd0);

    // Reset arrives while a load is stalled in its memory access.
    buildInstr(7'h03, 3'd2, 1'b0, 1, 3);
    for (int i = 0; i < 3; i++) begin
      void'(tagQ.pop_back()); void'(readyQ.pop_back());
      void'(expQ.pop_back()); void'(retQ.pop_back());
    end
    applyStimulus();
    doReset();
    buildInstr(7'h13, 3'($urandom), 1'b0, 0, 0);
    applyStimulus();

    buildInstr(7'h7F, 3'd0, 1'b0, 1, 0);
    applyStimulus();
    doReset();

    begin
      ctrl_t w;
      for (int i = 0; i < TIMEOUT; i++) begin
        w = '0; w.memReq = 1; w.srcB = 2'd1;
        push("fetchStall", 1'b0, w, 0);
      end
      w = '0; w.trap = 1; w.cause = 2'd2;
      for (int i = 0; i < 4; i++) push("trapBus", 1'($urandom), w, 0);
      applyStimulus();
    end
    doReset();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
